// File: rtl/linear_layer_start_fifo_ctrl_pkg.sv
// Shared types and helpers for the start-token FIFO: occupancy state encoding
// and the width of the occupancy counter derived from the address width.
package linear_layer_start_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

    // One extra bit so the counter can hold DEPTH == 2**addr_width.
    function automatic int occ_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// Shift-chain token storage: a write shifts every entry one deeper and lands din at index 0.
// Read is combinational (dout = mem[addr]); no reset, contents are don't-care until written.
module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// First-word fall-through start-token FIFO: counter, registered flags and FSM around an SRL.
// Push lands next edge; full/empty flags are registered from next state, so requests at full/empty are dropped.
module linear_layer_start_fifo_ctrl
    import linear_layer_start_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam int CW = occ_width(ADDR_WIDTH);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    fifo_state_t           state_q;
    fifo_state_t           state_nxt;
    logic [CW-1:0]         cnt_q;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic                  full_n_nxt;
    logic                  empty_n_nxt;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign push = if_write_ce & if_write & full_n_q;
    assign pop  = if_read_ce & if_read & empty_n_q;

    // Oldest token sits at cnt-1; a simultaneous push/pop shifts the next-oldest into that slot.
    assign rd_addr = (cnt_q != '0) ? ADDR_WIDTH'(cnt_q - ONE) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + ONE;
                2'b01:   cnt_q <= cnt_q - ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            empty_n_q <= empty_n_nxt;
            full_n_q  <= full_n_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) state_nxt = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && (cnt_q == CAP - ONE)) begin
                    state_nxt = ST_FULL;
                end else if (pop && !push && (cnt_q == ONE)) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) state_nxt = (DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        empty_n_nxt = (state_nxt != ST_EMPTY);
        full_n_nxt  = (state_nxt != ST_FULL);
    end

    linear_layer_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (push),
        .addr (rd_addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = cnt_q;
    assign if_fifo_cap       = CAP;

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Directed bench for the start-token FIFO at DEPTH=7 with a queue holding the expected token order.
module tb_linear_layer_start_fifo_ctrl;

    localparam int DW = 1;
    localparam int AW = 3;
    localparam int DP = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;

    int checks = 0;
    int errors = 0;
    logic q[$];

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tok(input logic d);
        if_write_ce = 1'b1;
        if_write    = 1'b1;
        if_din      = d;
        step();
        if_write    = 1'b0;
        if_write_ce = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        if_write_ce = 1'b0;
        if_write    = 1'b0;
        if_din      = '0;
        if_read_ce  = 1'b0;
        if_read     = 1'b0;
        #12;
        check("rst_empty_n", 32'(if_empty_n), 0);
        check("rst_full_n", 32'(if_full_n), 1);
        check("rst_cnt", 32'(if_num_data_valid), 0);
        check("rst_cap", 32'(if_fifo_cap), 7);
        reset = 1'b0;
        step();

        // write request without its enable qualifier
        if_write = 1'b1;
        if_din   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("noce_cnt", 32'(if_num_data_valid), 0);
            check("noce_empty_n", 32'(if_empty_n), 0);
            check("noce_cap", 32'(if_fifo_cap), 7);
        end
        if_write = 1'b0;

        // push 1,0,1
        push_tok(1'b1); q.push_back(1'b1);
        check("p1_empty_n", 32'(if_empty_n), 1);
        check("p1_dout", 32'(if_dout), 1);
        check("p1_cnt", 32'(if_num_data_valid), 1);
        push_tok(1'b0); q.push_back(1'b0);
        push_tok(1'b1); q.push_back(1'b1);
        check("p3_cnt", 32'(if_num_data_valid), 3);
        check("p3_dout", 32'(if_dout), 1);

        // fill to 7 with 0,1,1,0
        push_tok(1'b0); q.push_back(1'b0);
        push_tok(1'b1); q.push_back(1'b1);
        push_tok(1'b1); q.push_back(1'b1);
        check("p6_full_n", 32'(if_full_n), 1);
        push_tok(1'b0); q.push_back(1'b0);
        check("p7_full_n", 32'(if_full_n), 0);
        check("p7_cnt", 32'(if_num_data_valid), 7);

        // push while full is dropped
        push_tok(1'b1);
        check("p8_cnt", 32'(if_num_data_valid), 7);
        check("p8_full_n", 32'(if_full_n), 0);

        // drain in push order
        if_read_ce = 1'b1;
        if_read    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("pop_dout", 32'(if_dout), 32'(q[0]));
            step();
            q.delete(0);
            check("pop_cnt", 32'(if_num_data_valid), 32'(6 - i));
            if (i == 0) check("pop1_full_n", 32'(if_full_n), 1);
        end
        check("drain_empty_n", 32'(if_empty_n), 0);
        step();
        check("xpop_cnt", 32'(if_num_data_valid), 0);
        check("xpop_empty_n", 32'(if_empty_n), 0);
        if_read    = 1'b0;
        if_read_ce = 1'b0;

        // simultaneous push/pop at cnt=3
        push_tok(1'b1); q.push_back(1'b1);
        push_tok(1'b1); q.push_back(1'b1);
        push_tok(1'b0); q.push_back(1'b0);
        if_write_ce = 1'b1;
        if_write    = 1'b1;
        if_din      = 1'b0;
        if_read_ce  = 1'b1;
        if_read     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_dout", 32'(if_dout), 32'(q[0]));
            step();
            q.delete(0);
            q.push_back(1'b0);
            check("pp_cnt", 32'(if_num_data_valid), 3);
        end
        if_write_ce = 1'b0;
        if_write    = 1'b0;
        if_read_ce  = 1'b0;
        if_read     = 1'b0;

        // reach cnt=5, then reset asynchronously between edges
        push_tok(1'b1);
        push_tok(1'b1);
        check("pre_rst_cnt", 32'(if_num_data_valid), 5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_empty_n", 32'(if_empty_n), 0);
        check("arst_full_n", 32'(if_full_n), 1);
        check("arst_cnt", 32'(if_num_data_valid), 0);
        step();
        reset = 1'b0;
        step();
        q.delete();

        // first push after reset behaves as push into empty
        push_tok(1'b0);
        check("post_empty_n", 32'(if_empty_n), 1);
        check("post_cnt", 32'(if_num_data_valid), 1);
        check("post_dout", 32'(if_dout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
